decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl_pkg.sv | 168 ++++++++++++++++
 rtl/decode_ctrl_if.sv | 37 +++
 rtl/decode_ctrl_cond_eval.sv | 33 +++
 rtl/decode_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_decode_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared encodings for the instruction decode controller: opcode/func/cond
// codes, FSM states, flag bit positions and the decode helpers.
// Optional feature macro: MULT_EN (fmul / muli become legal instructions).
package decode_ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FIELD_W = 4;
    localparam int unsigned FLAG_W  = 5;

    // Flag bit positions within psr / alu_flags = {c,l,f,z,n}
    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_L = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    // Major opcodes
    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_SPEC  = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_SUBCI = 4'b1010;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_MULI  = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Register-class func codes (0000, 1000, 1100 unused)
    localparam logic [3:0] FN_AND  = 4'b0001;
    localparam logic [3:0] FN_OR   = 4'b0010;
    localparam logic [3:0] FN_XOR  = 4'b0011;
    localparam logic [3:0] FN_NOT  = 4'b0100;
    localparam logic [3:0] FN_ADD  = 4'b0101;
    localparam logic [3:0] FN_ADDU = 4'b0110;
    localparam logic [3:0] FN_ADDC = 4'b0111;
    localparam logic [3:0] FN_SUB  = 4'b1001;
    localparam logic [3:0] FN_SUBC = 4'b1010;
    localparam logic [3:0] FN_CMP  = 4'b1011;
    localparam logic [3:0] FN_MOV  = 4'b1101;
    localparam logic [3:0] FN_MUL  = 4'b1110;
    localparam logic [3:0] FN_TEST = 4'b1111;

    // Shift-class func codes
    localparam logic [3:0] SH_LSH  = 4'b0000;
    localparam logic [3:0] SH_LSHI = 4'b0001;
    localparam logic [3:0] SH_ASH  = 4'b0010;
    localparam logic [3:0] SH_ASHI = 4'b0011;
    localparam logic [3:0] SH_ROT  = 4'b0100;
    localparam logic [3:0] SH_ROTI = 4'b0110;

    // Special-class func codes
    localparam logic [3:0] SP_LOAD  = 4'b0000;
    localparam logic [3:0] SP_STOR  = 4'b0100;
    localparam logic [3:0] SP_JAL   = 4'b1000;
    localparam logic [3:0] SP_JCOND = 4'b1100;
    localparam logic [3:0] SP_SCOND = 4'b1101;

    // Condition codes
    localparam logic [3:0] CC_EQ  = 4'd0;
    localparam logic [3:0] CC_NE  = 4'd1;
    localparam logic [3:0] CC_CS  = 4'd2;
    localparam logic [3:0] CC_CC  = 4'd3;
    localparam logic [3:0] CC_LO  = 4'd4;
    localparam logic [3:0] CC_NLO = 4'd5;
    localparam logic [3:0] CC_LT  = 4'd6;
    localparam logic [3:0] CC_GE  = 4'd7;
    localparam logic [3:0] CC_FS  = 4'd8;
    localparam logic [3:0] CC_FC  = 4'd9;
    localparam logic [3:0] CC_HI  = 4'd10;
    localparam logic [3:0] CC_LS  = 4'd11;
    localparam logic [3:0] CC_GT  = 4'd12;
    localparam logic [3:0] CC_LE  = 4'd13;
    localparam logic [3:0] CC_UC  = 4'd14;
    localparam logic [3:0] CC_NV  = 4'd15;

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] oper;
        logic [FIELD_W-1:0] rdst;
        logic [FIELD_W-1:0] func;
        logic [FIELD_W-1:0] rsrc;
    } instr_t;

    typedef struct packed {
        logic illegal;
        logic writes;
        logic sets_psr;
        logic mem;
        logic stor;
        logic bcond;
        logic jcond;
        logic jal;
    } dec_t;

    // Classify an instruction into its writeback / flag / control effects
    function automatic dec_t decode(input logic [3:0] oper, input logic [3:0] func);
        dec_t d;
        d = '0;
        case (oper)
            OP_REG: begin
                case (func)
                    FN_AND, FN_OR, FN_XOR, FN_NOT,
                    FN_ADD, FN_ADDC, FN_SUB:          begin d.writes = 1'b1; d.sets_psr = 1'b1; end
                    FN_ADDU, FN_SUBC, FN_MOV:         d.writes = 1'b1;
                    FN_CMP, FN_TEST:                  d.sets_psr = 1'b1;
                    FN_MUL: begin
`ifdef MULT_EN
                        d.writes = 1'b1;
`else
                        d.illegal = 1'b1;
`endif
                    end
                    default:                          d.illegal = 1'b1;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI,
            OP_ADDI, OP_ADDCI, OP_SUBI:               begin d.writes = 1'b1; d.sets_psr = 1'b1; end
            OP_CMPI:                                  d.sets_psr = 1'b1;
            OP_ADDUI, OP_SUBCI, OP_MOVI, OP_LUI:      d.writes = 1'b1;
            OP_MULI: begin
`ifdef MULT_EN
                d.writes = 1'b1;
`else
                d.illegal = 1'b1;
`endif
            end
            OP_SHIFT: begin
                case (func)
                    SH_LSH, SH_LSHI, SH_ASH, SH_ASHI,
                    SH_ROT, SH_ROTI:                  d.writes = 1'b1;
                    default:                          d.illegal = 1'b1;
                endcase
            end
            OP_BCOND:                                 d.bcond = 1'b1;
            OP_SPEC: begin
                case (func)
                    SP_LOAD:                          begin d.mem = 1'b1; d.writes = 1'b1; end
                    SP_STOR:                          begin d.mem = 1'b1; d.stor = 1'b1; end
                    SP_JAL:                           begin d.jal = 1'b1; d.writes = 1'b1; end
                    SP_JCOND:                         d.jcond = 1'b1;
                    SP_SCOND:                         d.writes = 1'b1;
                    default:                          d.illegal = 1'b1;
                endcase
            end
            default:                                  d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // Immediate: sign-extended for arithmetic-signed ops and branch offsets
    function automatic logic [INSTR_W-1:0] imm_ext(input instr_t i);
        logic [7:0] raw;
        raw = {i.func, i.rsrc};
        case (i.oper)
            OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI, OP_MULI, OP_BCOND: return {{8{raw[7]}}, raw};
            default:                                              return {8'h00, raw};
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// Instruction / ALU / memory control bundle between decode_ctrl and its neighbours.
interface decode_ctrl_if;
    import decode_ctrl_pkg::*;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr;
    logic [FIELD_W-1:0]   oper;
    logic [FIELD_W-1:0]   func;
    logic [FIELD_W-1:0]   cond;
    logic                 imm_sel;
    logic [INSTR_W-1:0]   imm;
    logic [FIELD_W-1:0]   rdst;
    logic [FIELD_W-1:0]   rsrc;
    logic [FLAG_W-1:0]    alu_flags;
    logic [FLAG_W-1:0]    psr;
    logic                 reg_we;
    logic                 br_taken;
    logic                 jmp_taken;
    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_ack;
    logic                 illegal_op;
    logic                 mem_err;

    modport master (
        input  instr_valid, instr, alu_flags, mem_ack,
        output instr_ready, oper, func, cond, imm_sel, imm, rdst, rsrc, psr,
               reg_we, br_taken, jmp_taken, mem_req, mem_we, illegal_op, mem_err
    );

    modport slave (
        output instr_valid, instr, alu_flags, mem_ack,
        input  instr_ready, oper, func, cond, imm_sel, imm, rdst, rsrc, psr,
               reg_we, br_taken, jmp_taken, mem_req, mem_we, illegal_op, mem_err
    );
endinterface

// File: rtl/decode_ctrl_cond_eval.sv
// Combinational branch/jump/set condition evaluation from the psr flags.
module cond_eval
    import decode_ctrl_pkg::*;
(
    input  logic [FLAG_W-1:0]  psr,
    input  logic [FIELD_W-1:0] cond,
    output logic               taken
);

    // Map condition code onto flag expression
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken =  psr[FLAG_Z];
            CC_NE:   taken = !psr[FLAG_Z];
            CC_CS:   taken =  psr[FLAG_C];
            CC_CC:   taken = !psr[FLAG_C];
            CC_LO:   taken =  psr[FLAG_L];
            CC_NLO:  taken = !psr[FLAG_L];
            CC_LT:   taken =  psr[FLAG_N];
            CC_GE:   taken = !psr[FLAG_N];
            CC_FS:   taken =  psr[FLAG_F];
            CC_FC:   taken = !psr[FLAG_F];
            CC_HI:   taken = !psr[FLAG_L] && !psr[FLAG_Z];
            CC_LS:   taken =  psr[FLAG_L] ||  psr[FLAG_Z];
            CC_GT:   taken = !psr[FLAG_N] && !psr[FLAG_Z];
            CC_LE:   taken =  psr[FLAG_N] ||  psr[FLAG_Z];
            CC_UC:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Instruction decode/control FSM: IDLE -> EXEC -> (MEM) -> WB -> IDLE.
// Optional feature macro: MULT_EN (see decode_ctrl_pkg).
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
)
(
    input  logic          clk,
    input  logic          reset,
    decode_ctrl_if.master bus
);

    localparam int unsigned     CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [FIELD_W-1:0]   oper_q, oper_d, func_q, func_d, cond_q, cond_d;
    logic [FIELD_W-1:0]   rdst_q, rdst_d, rsrc_q, rsrc_d;
    logic [INSTR_W-1:0]   imm_q, imm_d;
    logic                 imm_sel_q, imm_sel_d;
    logic [FLAG_W-1:0]    psr_q, psr_d, flags_q, flags_d;
    logic                 psr_upd_q, psr_upd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 reg_we_q, reg_we_d, br_q, br_d, jmp_q, jmp_d;
    logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic                 ill_q, ill_d, merr_q, merr_d;
    logic                 taken;
    instr_t               ins;
    dec_t                 dec;

    cond_eval u_cond_eval (
        .psr   (psr_q),
        .cond  (cond_q),
        .taken (taken)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        oper_d    = oper_q;
        func_d    = func_q;
        cond_d    = cond_q;
        rdst_d    = rdst_q;
        rsrc_d    = rsrc_q;
        imm_d     = imm_q;
        imm_sel_d = imm_sel_q;
        psr_d     = psr_q;
        flags_d   = flags_q;
        psr_upd_d = psr_upd_q;
        cnt_d     = cnt_q;
        reg_we_d  = 1'b0;
        br_d      = 1'b0;
        jmp_d     = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        ill_d     = 1'b0;
        merr_d    = 1'b0;
        ins       = instr_t'(bus.instr);
        dec       = decode(oper_q, func_q);

        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    state_d   = EXEC;
                    oper_d    = ins.oper;
                    func_d    = ins.func;
                    rdst_d    = ins.rdst;
                    rsrc_d    = ins.rsrc;
                    imm_d     = imm_ext(ins);
                    imm_sel_d = !(ins.oper inside {OP_REG, OP_SPEC, OP_SHIFT});
                    psr_upd_d = 1'b0;
                    if (ins.oper == OP_BCOND ||
                        (ins.oper == OP_SPEC && (ins.func == SP_JCOND || ins.func == SP_SCOND)))
                        cond_d = ins.rdst;
                    else
                        cond_d = '0;
                end
            end
            EXEC: begin
                flags_d = bus.alu_flags;
                if (dec.mem) begin
                    state_d   = MEM;
                    mem_req_d = 1'b1;
                    mem_we_d  = dec.stor;
                    cnt_d     = '0;
                end else begin
                    state_d   = WB;
                    reg_we_d  = dec.writes;
                    br_d      = dec.bcond && taken;
                    jmp_d     = dec.jal || (dec.jcond && taken);
                    ill_d     = dec.illegal;
                    psr_upd_d = dec.sets_psr;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    state_d  = WB;
                    reg_we_d = dec.writes;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    merr_d  = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = dec.stor;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                state_d   = IDLE;
                psr_upd_d = 1'b0;
                if (psr_upd_q)
                    psr_d = flags_q;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and registered outputs; synchronous reset aborts any state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            oper_q    <= '0;
            func_q    <= '0;
            cond_q    <= '0;
            rdst_q    <= '0;
            rsrc_q    <= '0;
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
            psr_q     <= '0;
            flags_q   <= '0;
            psr_upd_q <= 1'b0;
            cnt_q     <= '0;
            reg_we_q  <= 1'b0;
            br_q      <= 1'b0;
            jmp_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            ill_q     <= 1'b0;
            merr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            oper_q    <= oper_d;
            func_q    <= func_d;
            cond_q    <= cond_d;
            rdst_q    <= rdst_d;
            rsrc_q    <= rsrc_d;
            imm_q     <= imm_d;
            imm_sel_q <= imm_sel_d;
            psr_q     <= psr_d;
            flags_q   <= flags_d;
            psr_upd_q <= psr_upd_d;
            cnt_q     <= cnt_d;
            reg_we_q  <= reg_we_d;
            br_q      <= br_d;
            jmp_q     <= jmp_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            ill_q     <= ill_d;
            merr_q    <= merr_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.oper        = oper_q;
    assign bus.func        = func_q;
    assign bus.cond        = cond_q;
    assign bus.rdst        = rdst_q;
    assign bus.rsrc        = rsrc_q;
    assign bus.imm         = imm_q;
    assign bus.imm_sel     = imm_sel_q;
    assign bus.psr         = psr_q;
    assign bus.reg_we      = reg_we_q;
    assign bus.br_taken    = br_q;
    assign bus.jmp_taken   = jmp_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.illegal_op  = ill_q;
    assign bus.mem_err     = merr_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: directed instructions push expected
// completion records; a negedge monitor checks each completed instruction.
module tb_decode_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ack_delay = 0;
    int   mem_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decode_ctrl_if bus();

    decode_ctrl #(.MEM_TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Pulse vector order: {reg_we, br_taken, jmp_taken, illegal_op, mem_err}
`ifdef MULT_EN
    localparam logic [4:0] MUL_P = 5'b10000;
`else
    localparam logic [4:0] MUL_P = 5'b00010;
`endif

    typedef struct {
        logic [15:0] ins;
        logic [4:0]  fl;
        int          ackd;
        logic [4:0]  p;
        logic [3:0]  rd;
        logic [15:0] im;
        logic [4:0]  ps;
        int          lat;
        int          mc;
        logic        mw;
        logic        rst;
    } vec_t;

    typedef struct {
        int          idx;
        logic [4:0]  p;
        logic [3:0]  rd;
        logic [15:0] im;
        logic [4:0]  ps;
        int          acc;
        int          lat;
        int          mc;
        logic        mw;
    } exp_t;

    localparam int NV = 23;
    vec_t vecs [NV] = '{
        '{16'h5123, 5'b00010, 0, 5'b10000, 4'h1, 16'h0023, 5'b00010, 2,   0,   1'b0, 1'b0}, // addi
        '{16'hC0FC, 5'b11111, 0, 5'b01000, 4'h0, 16'hFFFC, 5'b00010, 2,   0,   1'b0, 1'b0}, // beq taken
        '{16'h02B3, 5'b10000, 0, 5'b00000, 4'h2, 16'h00B3, 5'b10000, 2,   0,   1'b0, 1'b0}, // cmp
        '{16'hC0FC, 5'b00000, 0, 5'b00000, 4'h0, 16'hFFFC, 5'b10000, 2,   0,   1'b0, 1'b0}, // beq not taken
        '{16'hC205, 5'b00000, 0, 5'b01000, 4'h2, 16'h0005, 5'b10000, 2,   0,   1'b0, 1'b0}, // bcs taken
        '{16'h43C5, 5'b00000, 0, 5'b00000, 4'h3, 16'h00C5, 5'b10000, 2,   0,   1'b0, 1'b0}, // jcc not taken
        '{16'h4EC5, 5'b00000, 0, 5'b00100, 4'hE, 16'h00C5, 5'b10000, 2,   0,   1'b0, 1'b0}, // juc
        '{16'h4A87, 5'b00000, 0, 5'b10100, 4'hA, 16'h0087, 5'b10000, 2,   0,   1'b0, 1'b0}, // jal
        '{16'h41D0, 5'b00000, 0, 5'b10000, 4'h1, 16'h00D0, 5'b10000, 2,   0,   1'b0, 1'b0}, // scond
        '{16'h4302, 5'b00000, 3, 5'b10000, 4'h3, 16'h0002, 5'b10000, 5,   3,   1'b0, 1'b0}, // load ack 3
        '{16'h4245, 5'b00000, 2, 5'b00000, 4'h2, 16'h0045, 5'b10000, 4,   2,   1'b1, 1'b0}, // stor ack 2
        '{16'h01E2, 5'b11111, 0, MUL_P,    4'h1, 16'h00E2, 5'b10000, 2,   0,   1'b0, 1'b0}, // fmul
        '{16'h0182, 5'b11111, 0, 5'b00010, 4'h1, 16'h0082, 5'b10000, 2,   0,   1'b0, 1'b0}, // reg func 1000
        '{16'hE3FF, 5'b11111, 0, MUL_P,    4'h3, 16'hFFFF, 5'b10000, 2,   0,   1'b0, 1'b0}, // muli
        '{16'h8152, 5'b11111, 0, 5'b00010, 4'h1, 16'h0052, 5'b10000, 2,   0,   1'b0, 1'b0}, // shift 0101
        '{16'h8162, 5'b11111, 0, 5'b10000, 4'h1, 16'h0062, 5'b10000, 2,   0,   1'b0, 1'b0}, // shift 0110
        '{16'h4010, 5'b11111, 0, 5'b00010, 4'h0, 16'h0010, 5'b10000, 2,   0,   1'b0, 1'b0}, // special 0001
        '{16'h1380, 5'b00001, 0, 5'b10000, 4'h3, 16'h0080, 5'b00001, 2,   0,   1'b0, 1'b0}, // andi
        '{16'hD480, 5'b11111, 0, 5'b10000, 4'h4, 16'hFF80, 5'b00001, 2,   0,   1'b0, 1'b0}, // movi
        '{16'h0AF1, 5'b00100, 0, 5'b00000, 4'hA, 16'h00F1, 5'b00100, 2,   0,   1'b0, 1'b0}, // test
        '{16'h4302, 5'b00000, 0, 5'b00001, 4'h3, 16'h0002, 5'b00100, 256, 255, 1'b0, 1'b0}, // load timeout
        '{16'h4102, 5'b00000, 0, 5'b00000, 4'h0, 16'h0000, 5'b00000, 3,   2,   1'b0, 1'b1}, // reset mid-MEM
        '{16'h5123, 5'b00010, 0, 5'b10000, 4'h1, 16'h0023, 5'b00010, 2,   0,   1'b0, 1'b0}  // addi after reset
    };

    exp_t sb_q[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Issue one instruction once the block is ready; record its expectation
    task automatic issue(input int idx);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.instr_ready && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        if (!bus.instr_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait vec%0d: got 0 expected 1", idx);
        end
        ack_delay     = vecs[idx].ackd;
        bus.alu_flags = vecs[idx].fl;
        bus.instr     = vecs[idx].ins;
        e.idx = idx;
        e.p   = vecs[idx].p;
        e.rd  = vecs[idx].rd;
        e.im  = vecs[idx].im;
        e.ps  = vecs[idx].ps;
        e.acc = cyc + 1;
        e.lat = vecs[idx].lat;
        e.mc  = vecs[idx].mc;
        e.mw  = vecs[idx].mw;
        sb_q.push_back(e);
        bus.instr_valid = 1'b1;
        @(posedge clk); #2;
        bus.instr_valid = 1'b0;
    endtask

    // Memory responder: ack in the ack_delay-th cycle of a request (0 = never)
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (bus.mem_req === 1'b1) mem_cnt++;
            else                      mem_cnt = 0;
            bus.mem_ack = (ack_delay != 0) && (mem_cnt == ack_delay);
        end
    end

    // Completion monitor: one record per return to IDLE
    initial begin
        logic [4:0] seen_p;
        logic       seen_we;
        logic       prev_ready;
        int         req_run;
        exp_t       e;
        seen_p     = '0;
        seen_we    = 1'b0;
        prev_ready = 1'b1;
        req_run    = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) req_run++;
            if (reset === 1'b0) begin
                if (bus.mem_we === 1'b1) seen_we = 1'b1;
                seen_p = seen_p | {bus.reg_we, bus.br_taken, bus.jmp_taken, bus.illegal_op, bus.mem_err};
                if (bus.instr_ready && !prev_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got completion expected none");
                    end else begin
                        e = sb_q.pop_front();
                        chk("pulses",    e.idx, 32'(seen_p), 32'(e.p));
                        chk("rdst",      e.idx, 32'(bus.rdst), 32'(e.rd));
                        chk("imm",       e.idx, 32'(bus.imm), 32'(e.im));
                        chk("psr",       e.idx, 32'(bus.psr), 32'(e.ps));
                        chk("latency",   e.idx, 32'(cyc - e.acc), 32'(e.lat));
                        chk("mem_req_n", e.idx, 32'(req_run), 32'(e.mc));
                        chk("mem_we",    e.idx, 32'(seen_we), 32'(e.mw));
                    end
                    seen_p  = '0;
                    seen_we = 1'b0;
                    req_run = 0;
                end
                prev_ready = bus.instr_ready;
            end
        end
    end

    // Directed stimulus
    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.alu_flags   = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("rst_ready",  -1, 32'(bus.instr_ready), 32'd1);
        chk("rst_psr",    -1, 32'(bus.psr), 32'd0);
        chk("rst_mem_req",-1, 32'(bus.mem_req), 32'd0);
        chk("rst_reg_we", -1, 32'(bus.reg_we), 32'd0);
        chk("rst_imm",    -1, 32'(bus.imm), 32'd0);
        chk("rst_rdst",   -1, 32'(bus.rdst), 32'd0);
        chk("rst_oper",   -1, 32'(bus.oper), 32'd0);

        for (int i = 0; i < NV; i++) begin
            issue(i);
            if (vecs[i].rst) begin
                @(posedge clk); #2;
                @(posedge clk); #2;
                reset = 1'b1;
                @(posedge clk); #2;
                reset = 1'b0;
            end
        end

        for (int k = 0; k < 2000 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
